// File: rtl/sram_resp_ctrl.sv
// Single-port SRAM access controller shared by two owners (alpha, fill).
// One request in flight; completion is routed back to the owner latched at acceptance.
module sram_resp_ctrl #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 1536,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alpha_en,
    input  logic              fill_en,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic [DATA_W-1:0] a_read_data,
    output logic [DATA_W-1:0] f_read_data,
    output logic              a_done,
    output logic              f_done,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                alpha_q, alpha_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
    logic                a_done_q, a_done_d;
    logic                f_done_q, f_done_d;
    logic                timeout_q, timeout_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        alpha_d   = alpha_q;
        cnt_d     = cnt_q;
        a_rdata_d = a_rdata_q;
        f_rdata_d = f_rdata_q;
        a_done_d  = 1'b0;
        f_done_d  = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if ((read_enable || write_enable) && (alpha_en || fill_en)) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    wr_d    = write_enable;
                    alpha_d = alpha_en;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Data-ready wins over the timeout if both happen on the same edge.
                if (!mem_busy) begin
                    if (!wr_q) begin
                        if (alpha_q) a_rdata_d = mem_rdata;
                        else         f_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                a_done_d = alpha_q;
                f_done_d = !alpha_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the wide data registers are reset too, since the read-return ports must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            alpha_q   <= 1'b0;
            cnt_q     <= '0;
            a_rdata_q <= '0;
            f_rdata_q <= '0;
            a_done_q  <= 1'b0;
            f_done_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            alpha_q   <= alpha_d;
            cnt_q     <= cnt_d;
            a_rdata_q <= a_rdata_d;
            f_rdata_q <= f_rdata_d;
            a_done_q  <= a_done_d;
            f_done_q  <= f_done_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_rd      = (state_q == S_ISSUE) && !wr_q;
    assign mem_wr      = (state_q == S_ISSUE) &&  wr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign a_read_data = a_rdata_q;
    assign f_read_data = f_rdata_q;
    assign a_done      = a_done_q;
    assign f_done      = f_done_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sram_resp_ctrl.sv
// Scoreboard bench for sram_resp_ctrl: expected completions are queued at request time
// and checked against the DUT when a done pulse appears.
module tb_sram_resp_ctrl;

    localparam int AW = 24;
    localparam int DW = 1536;
    localparam int MW = 4;

    typedef struct {
        logic          alpha;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          tmo;
        int            lat;
        int            req_edge;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alpha_en = 1'b0, fill_en = 1'b0;
    logic          read_enable = 1'b0, write_enable = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] write_data = '0;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_busy = 1'b0;
    logic [DW-1:0] a_read_data, f_read_data;
    logic          a_done, f_done, busy, timeout_err;

    sram_resp_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .alpha_en(alpha_en), .fill_en(fill_en),
        .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .write_data(write_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .a_read_data(a_read_data), .f_read_data(f_read_data),
        .a_done(a_done), .f_done(f_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, a_cnt = 0, f_cnt = 0;
    int exp_rd = 0, exp_wr = 0, exp_done = 0;
    int busy_cfg = 0, busy_left = 0;
    int req_edge = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [DW-1:0] m_a = '0, m_f = '0;
    logic          m_tmo = 1'b0;
    exp_t          exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model and strobe/done monitor: busy_cfg WAIT edges see mem_busy high after the strobe.
    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            if (mem_rd) rd_cnt++;
            if (mem_wr) wr_cnt++;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            busy_left = busy_cfg;
        end else begin
            mem_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
        if (a_done) a_cnt++;
        if (f_done) f_cnt++;
    end

    task automatic req(input logic rd, input logic wr, input logic ae, input logic fe,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rdv, input int bcfg);
        mem_rdata    = rdv;
        busy_cfg     = bcfg;
        read_enable  = rd;
        write_enable = wr;
        alpha_en     = ae;
        fill_en      = fe;
        address      = a;
        write_data   = wd;
        @(posedge clk);
        #1;
        req_edge     = cyc;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        alpha_en     = 1'b0;
        fill_en      = 1'b0;
    endtask

    task automatic push(input logic alpha, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rdv,
                        input logic tmo, input int lat);
        exp_t e;
        e.alpha = alpha; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rdv;
        e.tmo = tmo; e.lat = lat; e.req_edge = req_edge;
        exp_q.push_back(e);
        if (wr) exp_wr++;
        else    exp_rd++;
    endtask

    task automatic wait_done();
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (a_done || f_done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || exp_q.size() == 0) begin
            n_err++;
            $display("FAIL done_seen: got no done pulse (or no queued expectation) within 40 cycles, required one");
        end else begin
            e = exp_q.pop_front();
            exp_done++;
            if (e.tmo) m_tmo = 1'b1;
            else if (!e.wr) begin
                if (e.alpha) m_a = e.rdata;
                else         m_f = e.rdata;
            end
            n_cmp++;
            if ({a_done, f_done} !== {e.alpha, !e.alpha}) begin
                n_err++;
                $display("FAIL done_owner: got a_done/f_done=%b%b required %b%b", a_done, f_done, e.alpha, !e.alpha);
            end
            n_cmp++;
            if (cyc - e.req_edge !== 3 + e.lat) begin
                n_err++;
                $display("FAIL done_latency: got %0d edges required %0d", cyc - e.req_edge, 3 + e.lat);
            end
            n_cmp++;
            if (a_read_data !== m_a) begin
                n_err++;
                $display("FAIL a_read_data: got low %h required low %h", a_read_data[63:0], m_a[63:0]);
            end
            n_cmp++;
            if (f_read_data !== m_f) begin
                n_err++;
                $display("FAIL f_read_data: got low %h required low %h", f_read_data[63:0], m_f[63:0]);
            end
            n_cmp++;
            if (timeout_err !== m_tmo) begin
                n_err++;
                $display("FAIL timeout_err: got %b required %b", timeout_err, m_tmo);
            end
            n_cmp++;
            if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
                n_err++;
                $display("FAIL strobe_count: got rd=%0d wr=%0d required rd=%0d wr=%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
            end
            n_cmp++;
            if (a_cnt + f_cnt !== exp_done) begin
                n_err++;
                $display("FAIL done_count: got %0d done cycles required %0d", a_cnt + f_cnt, exp_done);
            end
            n_cmp++;
            if (cap_addr !== e.addr) begin
                n_err++;
                $display("FAIL mem_addr: got %h required %h", cap_addr, e.addr);
            end
            if (e.wr) begin
                n_cmp++;
                if (cap_wdata !== e.wdata) begin
                    n_err++;
                    $display("FAIL mem_wdata: got low %h required low %h", cap_wdata[63:0], e.wdata[63:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, mem_rd, mem_wr, a_done, f_done, timeout_err} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || a_read_data !== '0 || f_read_data !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b rd=%b wr=%b ad=%b fd=%b tmo=%b addr=%h required all zero",
                     busy, mem_rd, mem_wr, a_done, f_done, timeout_err, mem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_alpha_read();
        req(1'b1, 1'b0, 1'b1, 1'b0, 24'h000010, '0, {DW/8{8'hA5}}, 0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: got %b required 1", busy);
        end
        push(1'b1, 1'b0, 24'h000010, '0, {DW/8{8'hA5}}, 1'b0, 0);
        wait_done();
    endtask

    task automatic test_fill_write();
        req(1'b0, 1'b1, 1'b0, 1'b1, 24'h00ABCD, {DW/8{8'h3C}}, {DW/8{8'hFF}}, 3);
        push(1'b0, 1'b1, 24'h00ABCD, {DW/8{8'h3C}}, '0, 1'b0, 3);
        wait_done();
        // read and write strobed together must be taken as a write
        req(1'b1, 1'b1, 1'b1, 1'b0, 24'h000777, {DW/8{8'h96}}, {DW/8{8'hEE}}, 0);
        push(1'b1, 1'b1, 24'h000777, {DW/8{8'h96}}, '0, 1'b0, 0);
        wait_done();
    endtask

    task automatic test_owner_swap();
        req(1'b1, 1'b0, 1'b1, 1'b0, 24'h000044, '0, {DW/8{8'h71}}, 2);
        push(1'b1, 1'b0, 24'h000044, '0, {DW/8{8'h71}}, 1'b0, 2);
        @(posedge clk);
        #1;
        alpha_en = 1'b0;
        fill_en  = 1'b1;
        wait_done();
        fill_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        req(1'b1, 1'b0, 1'b0, 1'b1, 24'h000020, '0, {DW/8{8'h5A}}, 0);
        push(1'b0, 1'b0, 24'h000020, '0, {DW/8{8'h5A}}, 1'b0, 0);
        wait_done();
        req(1'b1, 1'b0, 1'b1, 1'b1, 24'h000021, '0, {DW/8{8'hC3}}, 1);
        push(1'b1, 1'b0, 24'h000021, '0, {DW/8{8'hC3}}, 1'b0, 1);
        wait_done();
    endtask

    task automatic test_overlap_drop();
        req(1'b1, 1'b0, 1'b0, 1'b1, 24'h000100, '0, {DW/8{8'h0F}}, 3);
        push(1'b0, 1'b0, 24'h000100, '0, {DW/8{8'h0F}}, 1'b0, 3);
        @(posedge clk);
        #1;
        read_enable = 1'b1;
        alpha_en    = 1'b1;
        address     = 24'h000200;
        @(posedge clk);
        #1;
        read_enable = 1'b0;
        alpha_en    = 1'b0;
        wait_done();
        req(1'b1, 1'b0, 1'b0, 1'b0, 24'h000300, '0, {DW/8{8'h99}}, 0);
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rd_cnt !== exp_rd || a_cnt + f_cnt !== exp_done) begin
            n_err++;
            $display("FAIL no_owner_drop: got busy=%b rd=%0d done=%0d required busy=0 rd=%0d done=%0d",
                     busy, rd_cnt, a_cnt + f_cnt, exp_rd, exp_done);
        end
    endtask

    task automatic test_timeout();
        req(1'b1, 1'b0, 1'b1, 1'b0, 24'h000400, '0, {DW/8{8'h11}}, 255);
        push(1'b1, 1'b0, 24'h000400, '0, {DW/8{8'h11}}, 1'b1, MW - 1);
        wait_done();
        // sticky flag must survive a later clean access
        req(1'b1, 1'b0, 1'b0, 1'b1, 24'h000401, '0, {DW/8{8'h22}}, 1);
        push(1'b0, 1'b0, 24'h000401, '0, {DW/8{8'h22}}, 1'b0, 1);
        wait_done();
    endtask

    task automatic test_reset_mid_op();
        int done_before;
        req(1'b1, 1'b0, 1'b1, 1'b0, 24'h000500, '0, {DW/8{8'h44}}, 10);
        exp_rd++;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        done_before = a_cnt + f_cnt;
        m_a = '0; m_f = '0; m_tmo = 1'b0;
        n_cmp++;
        if ({busy, mem_rd, mem_wr, a_done, f_done, timeout_err} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || a_read_data !== '0 || f_read_data !== '0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b tmo=%b addr=%h a_rd_low=%h required all zero",
                     busy, timeout_err, mem_addr, a_read_data[31:0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (a_cnt + f_cnt !== done_before) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d done cycles required %0d", a_cnt + f_cnt, done_before);
        end
        req(1'b1, 1'b0, 1'b1, 1'b0, 24'h000600, '0, {DW/8{8'h6E}}, 0);
        push(1'b1, 1'b0, 24'h000600, '0, {DW/8{8'h6E}}, 1'b0, 0);
        wait_done();
    endtask

    initial begin
        test_reset();
        test_alpha_read();
        test_fill_write();
        test_owner_swap();
        test_back_to_back();
        test_overlap_drop();
        test_timeout();
        test_reset_mid_op();
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (a_cnt + f_cnt !== exp_done || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_counts: got %0d done cycles, %0d pending required %0d and 0",
                     a_cnt + f_cnt, exp_q.size(), exp_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
